// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake. Single-cycle logic/arithmetic ops,
// iterative one-bit-per-cycle shifter for SLL/SRL/SRA.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpSlt = 4'b0010;
    localparam logic [3:0] OpXor = 4'b0011;
    localparam logic [3:0] OpOr  = 4'b0100;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpSll = 4'b0110;
    localparam logic [3:0] OpSrl = 4'b0111;
    localparam logic [3:0] OpSra = 4'b1000;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t           state_q;
    logic [SW-1:0]    cnt_q;
    logic [WIDTH-1:0] work_q;
    logic [3:0]       op_q;

    logic             accept;
    logic             is_shift;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] work_next;

    assign in_ready = !flush && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    assign accept   = in_valid && in_ready;
    assign shamt    = src_b[SW-1:0];
    assign is_shift = (alu_opcode == OpSll) || (alu_opcode == OpSrl) || (alu_opcode == OpSra);

    // Shift opcodes only reach this path with a zero shift amount, so they pass src_a.
    always_comb begin
        alu_res = src_a + src_b;
        case (alu_opcode)
            OpAdd:   alu_res = src_a + src_b;
            OpSub:   alu_res = src_a - src_b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OpXor:   alu_res = src_a ^ src_b;
            OpOr:    alu_res = src_a | src_b;
            OpAnd:   alu_res = src_a & src_b;
            OpSll, OpSrl, OpSra: alu_res = src_a;
            default: alu_res = src_a + src_b;
        endcase
    end

    always_comb begin
        work_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        case (op_q)
            OpSll:   work_next = {work_q[WIDTH-2:0], 1'b0};
            OpSrl:   work_next = {1'b0, work_q[WIDTH-1:1]};
            default: work_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            busy      <= 1'b0;
            cnt_q     <= '0;
            work_q    <= '0;
            op_q      <= OpAdd;
        end else if (flush) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            work_q    <= src_a;
                            cnt_q     <= shamt;
                            op_q      <= alu_opcode;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            state_q   <= StShift;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end
                    end else if ((state_q == StDone) && out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StShift: begin
                    work_q <= work_next;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == SW'(1)) begin
                        result    <= work_next;
                        zero      <= (work_next == '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
